eje03_iniciador: RTL and testbench

//  Request-side partner of the eje03 controller. Drives R toward eje03 and

---
 rtl/eje03_iniciador.sv | 170 +++++++++++++++++
 tb/tb_eje03_iniciador.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eje03_iniciador.sv
// eje03_iniciador: request-side partner of the eje03 controller.
// Raises R toward eje03, waits for a_e, holds R for a programmable number of
// cycles, then waits for c. A start/done/err interface faces upper logic.
// A timeout guards both waits.
// Build option: define EJE03_CONTADOR_EN to enable the completed-transaction
// counter on txn_cnt. Without it, txn_cnt is tied to zero.
module eje03_iniciador #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             a_e,
    input  logic             c,
    output logic             R,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       txn_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_WAIT_C,
        S_DONE,
        S_ERR
    } state_t;

    // Value the timeout counter shows on the last permitted waiting cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_hold_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_req;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    state_t           w_state_nxt;
    logic [LEN_W-1:0] w_len_nxt;
    logic [LEN_W-1:0] w_hold_nxt;
    logic [TO_W-1:0]  w_to_nxt;

    // State, latched length and counters.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_hold_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_to_cnt   <= w_to_nxt;
        end
    end

    // Next-state and counter update rules.
    // NOTE: every signal gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_hold_nxt  = r_hold_cnt;
        w_to_nxt    = r_to_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_REQ;
                    w_len_nxt   = len;
                    w_to_nxt    = '0;
                end
            end
            S_REQ: begin
                // Acknowledge beats the timeout when both land together.
                if (a_e) begin
                    w_to_nxt = '0;
                    if (r_len == '0) begin
                        w_state_nxt = S_WAIT_C;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_hold_nxt  = r_len;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = S_ERR;
                    w_to_nxt    = '0;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_HOLD: begin
                // The last hold cycle is the one where the counter reads 1.
                if (r_hold_cnt <= LEN_W'(1)) begin
                    w_state_nxt = S_WAIT_C;
                    w_hold_nxt  = '0;
                    w_to_nxt    = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt - LEN_W'(1);
                end
            end
            S_WAIT_C: begin
                // Completion beats the timeout when both land together.
                if (c) begin
                    w_state_nxt = S_DONE;
                    w_to_nxt    = '0;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = S_ERR;
                    w_to_nxt    = '0;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_DONE, S_ERR: begin
                w_state_nxt = S_IDLE;
                w_to_nxt    = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_to_nxt    = '0;
            end
        endcase
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_req  <= (w_state_nxt == S_REQ) || (w_state_nxt == S_HOLD);
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
            r_err  <= (w_state_nxt == S_ERR);
        end
    end

    assign R    = r_req;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

`ifdef EJE03_CONTADOR_EN
    logic [7:0] r_txn_cnt;

    // Count each entry into DONE; wraps silently at 255.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_txn_cnt <= 8'd0;
        end else if (w_state_nxt == S_DONE) begin
            r_txn_cnt <= r_txn_cnt + 8'd1;
        end
    end

    assign txn_cnt = r_txn_cnt;
`else
    assign txn_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_eje03_iniciador.sv
// Self-checking bench for eje03_iniciador: a phase/age reference model is
// compared with the DUT on every falling edge. Directed scenarios pin the
// model with hand-computed values, and a randomized phase follows.
// Works with or without EJE03_CONTADOR_EN defined.
module tb_eje03_iniciador;

    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 15;
    localparam int TO_W    = 4;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len   = '0;
    logic             a_e   = 1'b0;
    logic             c     = 1'b0;
    logic             R;
    logic             busy;
    logic             done;
    logic             err;
    logic [7:0]       txn_cnt;

    int n_checks = 0;
    int n_errs   = 0;
    int n_rhigh, n_done, n_err, n_idle;

    always #5 clk = ~clk;

    eje03_iniciador #(
        .LEN_W  (LEN_W),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .len    (len),
        .a_e    (a_e),
        .c      (c),
        .R      (R),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .txn_cnt(txn_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            if (n_errs <= 30)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected txn_cnt after n completions since the last reset.
    function automatic logic [31:0] exp_cnt(input int n);
`ifdef EJE03_CONTADOR_EN
        return 32'(n % 256);
`else
        return 32'd0;
`endif
    endfunction

    // Reference model: which phase the transaction is in and how many cycles
    // it has already spent there.
    typedef enum int {P_IDLE, P_REQ, P_HOLD, P_WAITC, P_DONE, P_ERR} phase_t;
    phase_t m_phase = P_IDLE;
    int     m_age   = 0;
    int     m_len   = 0;
    int     m_cnt   = 0;

    always @(posedge clk or negedge reset) begin : model
        int age;
        if (!reset) begin
            m_phase <= P_IDLE;
            m_age   <= 0;
            m_len   <= 0;
            m_cnt   <= 0;
        end else begin
            age = m_age + 1;
            case (m_phase)
                P_IDLE: if (start) begin
                    m_phase <= P_REQ;
                    m_len   <= int'(len);
                    m_age   <= 0;
                end
                P_REQ: if (a_e) begin
                    m_phase <= (m_len == 0) ? P_WAITC : P_HOLD;
                    m_age   <= 0;
                end else if (age >= TIMEOUT) begin
                    m_phase <= P_ERR;
                end else begin
                    m_age <= age;
                end
                P_HOLD: if (age >= m_len) begin
                    m_phase <= P_WAITC;
                    m_age   <= 0;
                end else begin
                    m_age <= age;
                end
                P_WAITC: if (c) begin
                    m_phase <= P_DONE;
`ifdef EJE03_CONTADOR_EN
                    m_cnt <= (m_cnt + 1) % 256;
`endif
                end else if (age >= TIMEOUT) begin
                    m_phase <= P_ERR;
                end else begin
                    m_age <= age;
                end
                default: begin
                    m_phase <= P_IDLE;
                    m_age   <= 0;
                end
            endcase
        end
    end

    // Compare every output with the model on every falling edge.
    always @(negedge clk) begin
        logic [11:0] exp_v;
        exp_v = {(m_phase == P_REQ) || (m_phase == P_HOLD),
                 (m_phase != P_IDLE),
                 (m_phase == P_DONE),
                 (m_phase == P_ERR),
                 8'(m_cnt)};
        check("cycle_outputs", 32'({R, busy, done, err, txn_cnt}), 32'(exp_v));
    end

    task automatic clear_counts();
        n_rhigh = 0;
        n_done  = 0;
        n_err   = 0;
        n_idle  = 0;
    endtask

    // Apply inputs for one clock, then sample outputs on the falling edge.
    task automatic step(input logic s, input int l, input logic a, input logic cc);
        start = s;
        len   = LEN_W'(l);
        a_e   = a;
        c     = cc;
        @(negedge clk);
        if (R)     n_rhigh++;
        if (done)  n_done++;
        if (err)   n_err++;
        if (!busy) n_idle++;
    endtask

    initial begin
        int at;

        // Reset values.
        #3;
        check("reset_outputs", 32'({R, busy, done, err, txn_cnt}), 32'd0);
        #1 reset = 1'b1;
        @(negedge clk);

        // Nominal: len=3, ack on the 2nd REQ cycle, c on the 3rd WAIT_C cycle.
        clear_counts();
        step(1'b1, 3, 1'b0, 1'b0);
        step(1'b0, 3, 1'b0, 1'b0);
        step(1'b0, 3, 1'b1, 1'b0);
        repeat (5) step(1'b0, 3, 1'b0, 1'b0);
        step(1'b0, 3, 1'b0, 1'b1);
        step(1'b0, 3, 1'b0, 1'b0);
        check("nominal_r_cycles", 32'(n_rhigh), 32'd5);
        check("nominal_done", 32'(n_done), 32'd1);
        check("nominal_err", 32'(n_err), 32'd0);
        check("nominal_txn", 32'(txn_cnt), exp_cnt(1));

        // REQ timeout with no acknowledge.
        clear_counts();
        at = 0;
        step(1'b1, 2, 1'b0, 1'b0);
        for (int i = 2; i <= 40 && at == 0; i++) begin
            step(1'b0, 2, 1'b0, 1'b0);
            if (err) begin
                at = i;
                check("timeout_r_low_at_err", 32'(R), 32'd0);
            end
        end
        check("timeout_delay", 32'(at - 1), 32'(TIMEOUT));
        check("timeout_r_cycles", 32'(n_rhigh), 32'(TIMEOUT));
        step(1'b0, 2, 1'b0, 1'b0);
        check("timeout_after", 32'({R, busy, err}), 32'd0);
        check("timeout_txn", 32'(txn_cnt), exp_cnt(1));

        // Ties: ack on the timeout cycle of REQ, c on the timeout cycle of WAIT_C.
        clear_counts();
        step(1'b1, 1, 1'b0, 1'b0);
        repeat (TIMEOUT - 1) step(1'b0, 1, 1'b0, 1'b0);
        step(1'b0, 1, 1'b1, 1'b0);
        check("tie_ack_hold", 32'({R, busy, err}), 32'b110);
        step(1'b0, 1, 1'b0, 1'b0);
        check("tie_ack_wait_r", 32'(R), 32'd0);
        repeat (TIMEOUT - 1) step(1'b0, 1, 1'b0, 1'b0);
        step(1'b0, 1, 1'b0, 1'b1);
        check("tie_c_done", 32'({done, err}), 32'b10);
        step(1'b0, 1, 1'b0, 1'b0);
        check("tie_err_count", 32'(n_err), 32'd0);
        check("tie_txn", 32'(txn_cnt), exp_cnt(2));

        // len=0 back-to-back with start, a_e and c held high: period of 4.
        clear_counts();
        repeat (20) step(1'b1, 0, 1'b1, 1'b1);
        check("b2b_r_cycles", 32'(n_rhigh), 32'd5);
        check("b2b_done", 32'(n_done), 32'd5);
        check("b2b_idle", 32'(n_idle), 32'd5);
        check("b2b_err", 32'(n_err), 32'd0);
        step(1'b0, 0, 1'b0, 1'b0);
        check("b2b_txn", 32'(txn_cnt), exp_cnt(7));

        // Reset asserted in HOLD drops everything in the same time step.
        step(1'b1, 5, 1'b0, 1'b0);
        step(1'b0, 5, 1'b1, 1'b0);
        step(1'b0, 5, 1'b0, 1'b0);
        check("pre_reset_hold", 32'({R, busy}), 32'b11);
        #2 reset = 1'b0;
        #1;
        check("midop_reset", 32'({R, busy, done, err, txn_cnt}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 0, 1'b0, 1'b0);
        check("after_reset_idle", 32'(busy), 32'd0);

        // 256 completions wrap the counter.
        clear_counts();
        repeat (1020) step(1'b1, 0, 1'b1, 1'b1);
        check("wrap_255_done", 32'(n_done), 32'd255);
        check("wrap_255_txn", 32'(txn_cnt), exp_cnt(255));
        repeat (4) step(1'b1, 0, 1'b1, 1'b1);
        check("wrap_256_done", 32'(n_done), 32'd256);
        check("wrap_256_txn", 32'(txn_cnt), exp_cnt(256));
        step(1'b0, 0, 1'b0, 1'b0);

        // Randomized traffic, covered by the per-cycle model comparison.
        repeat (3000)
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        repeat (4) step(1'b0, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
